// File: rtl/simon_key_schedule_seq.sv
// SIMON key schedule, sequential: emits one round key per cycle from an M-word sliding window.
// Optional feature: define SIMON_KEY_CACHE_EN to add a T x N round-key cache that replays the
// schedule when the same master key is requested again.
module simon_key_schedule_seq #(
    parameter int unsigned N = 16,
    parameter int unsigned M = 4,
    parameter int unsigned T = 32,
    parameter int unsigned C = 5
) (
    input  logic             clk,
    input  logic             R,
    input  logic             newKey,
    input  logic [M*N-1:0]   key,
    input  logic             adv,
    output logic             ldKey,
    output logic [N-1:0]     rKey,
    output logic [C-1:0]     count,
    output logic             keyValid,
    output logic             doneKey,
    output logic             keyCached
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // z0 sequence, bit for index i sits at position 61-i
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

    function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int unsigned s);
        ror = (x >> s) | (x << (N - s));
    endfunction

    state_e         state_q, state_d;
    logic [C-1:0]   count_q, count_d;
    logic           ld_q, ld_d;
    logic [N-1:0]   w_q [M];
    logic [N-1:0]   w_d [M];
    logic [N-1:0]   tmp, new_word;
    logic [5:0]     zidx;
    logic           zbit;
    logic           last;
    logic           shift_en;

`ifdef SIMON_KEY_CACHE_EN
    logic [N-1:0]   cache_q [T];
    logic [N-1:0]   cache_d [T];
    logic [M*N-1:0] master_q, master_d;
    logic           cached_q, cached_d;
    logic           replay_q, replay_d;

    // Cache bookkeeping: refill on a new key, replay on a matching key
    always_comb begin
        cache_d  = cache_q;
        master_d = master_q;
        cached_d = cached_q;
        replay_d = replay_q;
        if (state_q == StRun && !replay_q) begin
            cache_d[count_q] = w_q[0];
        end
        if (newKey) begin
            if (cached_q && key == master_q) begin
                replay_d = 1'b1;
            end else begin
                replay_d = 1'b0;
                cached_d = 1'b0;
                master_d = key;
            end
        end else if (state_q == StRun && adv && last) begin
            cached_d = 1'b1;
        end
    end

    // Cache state registers
    always_ff @(posedge clk) begin
        if (R) begin
            master_q <= '0;
            cached_q <= 1'b0;
            replay_q <= 1'b0;
            for (int i = 0; i < int'(T); i++) cache_q[i] <= '0;
        end else begin
            master_q <= master_d;
            cached_q <= cached_d;
            replay_q <= replay_d;
            cache_q  <= cache_d;
        end
    end

    assign shift_en  = !replay_q;
    assign keyCached = cached_q;
    assign rKey      = replay_q ? cache_q[count_q] : w_q[0];
`else
    assign shift_en  = 1'b1;
    assign keyCached = 1'b0;
    assign rKey      = w_q[0];
`endif

    // Next window word k[count+M] from the current window
    always_comb begin
        tmp = ror(w_q[M-1], 3);
        if (M == 4) tmp = tmp ^ w_q[1];
        zidx     = 6'(32'(count_q) % 32'd62);
        zbit     = Z0[6'd61 - zidx];
        new_word = ~w_q[0] ^ tmp ^ ror(tmp, 1) ^ N'(32'd3) ^ {{(N-1){1'b0}}, zbit};
    end

    assign last = (count_q == C'(T - 1));

    // FSM next state, window and counter update; newKey outranks adv
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ld_d    = 1'b0;
        w_d     = w_q;
        if (newKey) begin
            state_d = StRun;
            count_d = '0;
            ld_d    = 1'b1;
            for (int j = 0; j < int'(M); j++) w_d[j] = key[j*N +: N];
        end else if (state_q == StRun && adv) begin
            if (last) begin
                state_d = StDone;
            end else begin
                count_d = count_q + 1'b1;
                if (shift_en) begin
                    for (int j = 0; j < int'(M) - 1; j++) w_d[j] = w_q[j+1];
                    w_d[M-1] = new_word;
                end
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (R) begin
            state_q <= StIdle;
            count_q <= '0;
            ld_q    <= 1'b0;
            for (int j = 0; j < int'(M); j++) w_q[j] <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ld_q    <= ld_d;
            w_q     <= w_d;
        end
    end

    assign ldKey    = ld_q;
    assign count    = count_q;
    assign keyValid = (state_q == StRun);
    assign doneKey  = (state_q == StDone);

endmodule
